// File: rtl/shift_chain_ctrl.sv
// Serial-chain sequencer: loads a parallel word, shifts it MSB-first onto sdo while
// capturing the chain's return bits from sdi, then pulses done with the captured word.
module shift_chain_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] din,
  output logic             sdo,
  output logic             sen,
  input  logic             sdi,
  output logic [WIDTH-1:0] dout,
  output logic             done,
  output logic             busy
);

  localparam int unsigned BCW = $clog2(WIDTH + 1);
  localparam int unsigned DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BCW-1:0] LastBit = BCW'(WIDTH - 1);
  localparam logic [DCW-1:0] DivMax  = DCW'(DIV - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DCW-1:0]     div_cnt_q, div_cnt_d;
  logic [WIDTH-1:0]   dout_q, dout_d;

  // Outputs decode straight from state so they take reset values without a clock edge.
  assign start_ready = (state_q == StIdle);
  assign sen         = (state_q == StShift) && (div_cnt_q == DivMax);
  assign sdo         = (state_q == StShift) ? shreg_q[WIDTH-1] : 1'b0;
  assign done        = (state_q == StDone);
  assign busy        = (state_q == StShift) || (state_q == StDone);
  assign dout        = dout_q;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    dout_d    = dout_q;
    unique case (state_q)
      StIdle: begin
        if (start_valid) begin
          shreg_d   = din;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        if (sen) begin
          shreg_d   = {shreg_q[WIDTH-2:0], sdi};
          bit_cnt_d = bit_cnt_q + BCW'(1);
          div_cnt_d = '0;
          if (bit_cnt_q == LastBit) begin
            dout_d  = {shreg_q[WIDTH-2:0], sdi};
            state_d = StDone;
          end
        end else begin
          div_cnt_d = div_cnt_q + DCW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      dout_q    <= dout_d;
    end
  end

endmodule

// File: tb/tb_shift_chain_ctrl.sv
// Directed bench for shift_chain_ctrl: one instance at DIV=1 (loopback or external sdi)
// and one at DIV=3, with hand-computed expectations.
module tb_shift_chain_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       sv0 = 1'b0, rdy0, sdo0, sen0, sdi0, done0, busy0;
  logic [7:0] din0 = '0, dout0;
  logic       loop0 = 1'b1, ext0 = 1'b0;

  logic       sv3 = 1'b0, rdy3, sdo3, sen3, done3, busy3;
  logic       sdi3 = 1'b0;
  logic [7:0] din3 = '0, dout3;

  int errors = 0;
  int checks = 0;

  assign sdi0 = loop0 ? sdo0 : ext0;

  always #5 clk = ~clk;

  shift_chain_ctrl #(.WIDTH(8), .DIV(1)) u0 (
    .clk(clk), .rst(rst), .start_valid(sv0), .start_ready(rdy0), .din(din0),
    .sdo(sdo0), .sen(sen0), .sdi(sdi0), .dout(dout0), .done(done0), .busy(busy0)
  );

  shift_chain_ctrl #(.WIDTH(8), .DIV(3)) u3 (
    .clk(clk), .rst(rst), .start_valid(sv3), .start_ready(rdy3), .din(din3),
    .sdo(sdo3), .sen(sen3), .sdi(sdi3), .dout(dout3), .done(done3), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge of cycle 1 (accept edge is cycle 0).
  task automatic accept0(input logic [7:0] d);
    sv0  = 1'b1;
    din0 = d;
    @(posedge clk);
    @(negedge clk);
    sv0  = 1'b0;
  endtask

  initial begin
    logic [7:0] e;
    logic       seen;

    // Reset state
    #2;
    chk("rst_ready0", rdy0, 1); chk("rst_busy0", busy0, 0); chk("rst_sdo0", sdo0, 0);
    chk("rst_sen0", sen0, 0);   chk("rst_done0", done0, 0); chk("rst_dout0", dout0, 0);
    chk("rst_ready3", rdy3, 1); chk("rst_busy3", busy3, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // DIV=1 loopback, A5
    e = 8'hA5;
    accept0(e);
    for (int k = 1; k <= 8; k++) begin
      chk("t2_sdo", sdo0, e[8-k]);
      chk("t2_sen", sen0, 1);
      chk("t2_done_low", done0, 0);
      @(negedge clk);
    end
    chk("t2_done", done0, 1); chk("t2_dout", dout0, 8'hA5);
    chk("t2_busy_done", busy0, 1); chk("t2_ready_done", rdy0, 0);
    @(negedge clk);
    chk("t2_done_clr", done0, 0); chk("t2_ready_idle", rdy0, 1); chk("t2_busy_idle", busy0, 0);

    // Async reset mid-run, observed without a clock edge
    accept0(8'hFF);
    @(negedge clk);
    @(negedge clk);
    chk("t1_pre_sdo", sdo0, 1); chk("t1_pre_busy", busy0, 1);
    rst = 1'b0;
    #1;
    chk("t1_ready", rdy0, 1); chk("t1_busy", busy0, 0); chk("t1_sen", sen0, 0);
    chk("t1_sdo", sdo0, 0);   chk("t1_done", done0, 0); chk("t1_dout", dout0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // DIV=3, sdi held high, 3C
    e    = 8'h3C;
    sdi3 = 1'b1;
    sv3  = 1'b1;
    din3 = e;
    @(posedge clk);
    @(negedge clk);
    sv3 = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      chk("t3_sen", sen3, (k % 3 == 0) ? 1 : 0);
      chk("t3_sdo", sdo3, e[7-(k-1)/3]);
      chk("t3_busy", busy3, 1);
      @(negedge clk);
    end
    chk("t3_done", done3, 1); chk("t3_dout", dout3, 8'hFF);
    @(negedge clk);
    chk("t3_done_clr", done3, 0); chk("t3_ready", rdy3, 1);

    // start_valid held through busy
    e    = 8'h11;
    sv0  = 1'b1;
    din0 = e;
    @(posedge clk);
    @(negedge clk);
    din0 = 8'h22;
    for (int k = 1; k <= 8; k++) begin
      chk("t4_sdo_a", sdo0, e[8-k]);
      chk("t4_ready_busy", rdy0, 0);
      @(negedge clk);
    end
    chk("t4_done_a", done0, 1); chk("t4_dout_a", dout0, 8'h11); chk("t4_ready_a", rdy0, 0);
    @(negedge clk);
    chk("t4_ready_idle", rdy0, 1); chk("t4_busy_idle", busy0, 0);
    @(posedge clk);
    @(negedge clk);
    sv0 = 1'b0;
    e   = 8'h22;
    for (int k = 1; k <= 8; k++) begin
      chk("t4_sdo_b", sdo0, e[8-k]);
      @(negedge clk);
    end
    chk("t4_done_b", done0, 1); chk("t4_dout_b", dout0, 8'h22);
    @(negedge clk);

    // Reset after the 4th sen of F0, then a clean 0F transaction
    accept0(8'hF0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_dout_clr", dout0, 0); chk("t5_done", done0, 0); chk("t5_busy", busy0, 0);
    @(negedge clk);
    rst  = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      if (done0) seen = 1'b1;
      @(negedge clk);
    end
    chk("t5_nodone", seen, 0); chk("t5_dout_hold", dout0, 0);
    accept0(8'h0F);
    repeat (8) @(negedge clk);
    chk("t5_done_new", done0, 1); chk("t5_dout_new", dout0, 8'h0F);
    @(negedge clk);

    // External sdi pattern, din=00
    loop0 = 1'b0;
    e     = 8'hCA;
    accept0(8'h00);
    for (int k = 1; k <= 8; k++) begin
      ext0 = e[8-k];
      chk("t6_sdo", sdo0, 0);
      @(negedge clk);
    end
    chk("t6_done", done0, 1); chk("t6_dout", dout0, 8'hCA);
    @(negedge clk);
    chk("t6_dout_held", dout0, 8'hCA); chk("t6_done_clr", done0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
